// File: rtl/wb_burst_master.sv
// Wishbone B4 burst master: one command becomes a classic cycle or an incrementing
// burst (linear or wrap-4/8/16). Read beats leave as pulses; write beats come from a valid/ready stream.
module wb_burst_master #(
  parameter int LEN_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [31:0]          cmd_addr,
  input  logic                 cmd_we,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  input  logic [1:0]           cmd_bte,
  input  logic [31:0]          wr_data,
  input  logic [3:0]           wr_sel,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  output logic [31:0]          rd_data,
  output logic                 rd_valid,
  output logic                 done,
  output logic                 err,
  output logic [31:0]          wbm_addr,
  output logic [31:0]          wbm_dat_w,
  output logic [3:0]           wbm_sel,
  output logic                 wbm_cyc,
  output logic                 wbm_stb,
  output logic                 wbm_we,
  output logic [2:0]           wbm_cti,
  output logic [1:0]           wbm_bte,
  input  logic [31:0]          wbm_dat_r,
  input  logic                 wbm_ack,
  input  logic                 wbm_err
);

  typedef enum logic {IDLE, BUS} state_t;

  state_t               state_q, state_d;
  logic [29:0]          addr_q, addr_next;
  logic                 we_q;
  logic [1:0]           bte_q;
  logic [LEN_WIDTH-1:0] rem_q, len_eff;
  logic                 single_q;
  logic                 in_bus, beat_ack, beat_err, last_beat, accept;

  assign in_bus    = (state_q == BUS);
  assign wbm_cyc   = in_bus;
  assign wbm_stb   = in_bus & (~we_q | wr_valid);
  assign wbm_we    = in_bus & we_q;
  assign wbm_addr  = {addr_q, 2'b00};
  assign wbm_bte   = bte_q;
  assign wbm_dat_w = wr_data;
  assign wbm_sel   = we_q ? wr_sel : 4'hF;

  // an error on the same beat as an ack wins, so the beat is never reported as data
  assign beat_err  = wbm_stb & wbm_err;
  assign beat_ack  = wbm_stb & wbm_ack & ~wbm_err;
  assign last_beat = (rem_q == LEN_WIDTH'(1));
  assign wr_ready  = beat_ack & we_q;
  assign accept    = cmd_valid & cmd_ready;
  assign len_eff   = (cmd_len == '0) ? LEN_WIDTH'(1) : cmd_len;

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = BUS;
      end
      BUS: begin
        if (beat_err || (beat_ack && last_beat)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if (!in_bus || single_q) wbm_cti = 3'b000;
    else if (last_beat)      wbm_cti = 3'b111;
    else                     wbm_cti = 3'b010;
  end

  // wrap bursts only advance the low word bits, the rest of the line address is held
  always_comb begin
    case (bte_q)
      2'b01:   addr_next = {addr_q[29:2], addr_q[1:0] + 2'd1};
      2'b10:   addr_next = {addr_q[29:3], addr_q[2:0] + 3'd1};
      2'b11:   addr_next = {addr_q[29:4], addr_q[3:0] + 4'd1};
      default: addr_next = addr_q + 30'd1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      bte_q    <= 2'b00;
      rem_q    <= '0;
      single_q <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= beat_ack & ~we_q;
      done     <= beat_err | (beat_ack & last_beat);
      err      <= beat_err;
      if (beat_ack && !we_q) rd_data <= wbm_dat_r;
      if (accept) begin
        addr_q   <= cmd_addr[31:2];
        we_q     <= cmd_we;
        bte_q    <= cmd_bte;
        rem_q    <= len_eff;
        single_q <= (len_eff == LEN_WIDTH'(1));
      end else if (beat_ack) begin
        addr_q <= addr_next;
        rem_q  <= rem_q - LEN_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master: a small Wishbone slave model plus a beat monitor
// whose logs are compared against hand-computed sequences.
module tb_wb_burst_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic        cmd_we = 1'b0;
  logic [4:0]  cmd_len = '0;
  logic [1:0]  cmd_bte = '0;
  logic [31:0] wr_data;
  logic [3:0]  wr_sel;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid, done, err;
  logic [31:0] wbm_addr, wbm_dat_w, wbm_dat_r;
  logic [3:0]  wbm_sel;
  logic        wbm_cyc, wbm_stb, wbm_we, wbm_ack, wbm_err;
  logic [2:0]  wbm_cti;
  logic [1:0]  wbm_bte;

  wb_burst_master #(.LEN_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_we(cmd_we), .cmd_len(cmd_len), .cmd_bte(cmd_bte),
    .wr_data(wr_data), .wr_sel(wr_sel), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
    .wbm_addr(wbm_addr), .wbm_dat_w(wbm_dat_w), .wbm_sel(wbm_sel),
    .wbm_cyc(wbm_cyc), .wbm_stb(wbm_stb), .wbm_we(wbm_we),
    .wbm_cti(wbm_cti), .wbm_bte(wbm_bte),
    .wbm_dat_r(wbm_dat_r), .wbm_ack(wbm_ack), .wbm_err(wbm_err)
  );

  always #5 clk = ~clk;

  // slave model: reads return address ^ 5A5A0000, writes land in a 4-word store
  logic        ack_en = 1'b1;
  logic        wr_en = 1'b1;
  int          err_at = 99;
  int          beat_idx = 0;
  int          wr_idx = 0;
  logic [31:0] wd   [4] = '{32'hAABBCCDD, 32'h12345678, 32'hCAFEF00D, 32'h0};
  logic [3:0]  ws   [4] = '{4'hF, 4'b0011, 4'b1000, 4'h0};
  logic [31:0] wmem [4];

  assign wbm_dat_r = 32'h5A5A0000 ^ wbm_addr;
  assign wbm_err   = wbm_cyc & wbm_stb & (beat_idx == err_at);
  assign wbm_ack   = wbm_cyc & wbm_stb & ack_en & ~wbm_err;
  assign wr_valid  = wr_en;
  assign wr_data   = wd[wr_idx[1:0]];
  assign wr_sel    = ws[wr_idx[1:0]];

  logic [31:0] addr_log[$];
  logic [31:0] rd_log[$];
  logic [2:0]  cti_log[$];
  logic [1:0]  bte_log[$];
  int          done_cnt = 0, wr_cnt = 0, stb_cnt = 0, gap_cnt = 0;
  logic        err_seen = 1'b0, cyc_at_done = 1'b1;
  logic [31:0] gap_addr = '0;
  logic [2:0]  gap_cti = '0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) wmem[i] <= 32'hFFFFFFFF;
    end
    if (cmd_valid && cmd_ready && !rst) begin
      addr_log.delete(); rd_log.delete(); cti_log.delete(); bte_log.delete();
      beat_idx <= 0; wr_idx <= 0; done_cnt <= 0; wr_cnt <= 0;
      stb_cnt <= 0; gap_cnt <= 0; err_seen <= 1'b0; cyc_at_done <= 1'b1;
    end else begin
      if (wbm_cyc && wbm_stb) stb_cnt <= stb_cnt + 1;
      if (wbm_cyc && !wbm_stb) begin
        gap_cnt  <= gap_cnt + 1;
        gap_addr <= wbm_addr;
        gap_cti  <= wbm_cti;
      end
      if (wbm_cyc && wbm_stb && (wbm_ack || wbm_err)) beat_idx <= beat_idx + 1;
      if (wbm_cyc && wbm_stb && wbm_ack) begin
        addr_log.push_back(wbm_addr);
        cti_log.push_back(wbm_cti);
        bte_log.push_back(wbm_bte);
        if (wbm_we)
          for (int b = 0; b < 4; b++)
            if (wbm_sel[b]) wmem[wbm_addr[3:2]][8*b +: 8] <= wbm_dat_w[8*b +: 8];
      end
      if (wr_ready) begin
        wr_cnt <= wr_cnt + 1;
        wr_idx <= wr_idx + 1;
      end
      if (rd_valid) rd_log.push_back(rd_data);
      if (done) begin
        done_cnt    <= done_cnt + 1;
        err_seen    <= err;
        cyc_at_done <= wbm_cyc;
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic issue(input logic [31:0] a, input logic [4:0] len, input logic we, input logic [1:0] bte);
    @(negedge clk);
    cmd_addr  = a;
    cmd_len   = len;
    cmd_we    = we;
    cmd_bte   = bte;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done_cnt != 0) break;
    end
    repeat (2) @(negedge clk);
    chk(tag, done_cnt, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cyc", {31'b0, wbm_cyc}, 0);
    chk("rst_stb", {31'b0, wbm_stb}, 0);
    chk("rst_cti", {29'b0, wbm_cti}, 0);
    chk("rst_addr", wbm_addr, 0);
    chk("rst_done", {31'b0, done}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", {31'b0, cmd_ready}, 1);

    // classic read
    issue(32'h0000_0101, 5'd1, 1'b0, 2'b00);
    wait_done("classic_done");
    chk("classic_stb_cycles", stb_cnt, 1);
    chk("classic_addr", addr_log[0], 32'h100);
    chk("classic_cti", {29'b0, cti_log[0]}, 0);
    chk("classic_rd_cnt", rd_log.size(), 1);
    chk("classic_rd_data", rd_log[0], 32'h5A5A0100);
    chk("classic_err", {31'b0, err_seen}, 0);
    chk("classic_cyc_at_done", {31'b0, cyc_at_done}, 0);

    // linear burst of 4, slave waits one cycle before acking
    ack_en = 1'b0;
    issue(32'h200, 5'd4, 1'b0, 2'b00);
    @(posedge clk);
    #1 ack_en = 1'b1;
    wait_done("lin_done");
    chk("lin_stb_cycles", stb_cnt, 5);
    chk("lin_beats", addr_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("lin_addr%0d", i), addr_log[i], 32'h200 + 32'(4 * i));
      chk($sformatf("lin_cti%0d", i), {29'b0, cti_log[i]}, (i == 3) ? 32'd7 : 32'd2);
      chk($sformatf("lin_rd%0d", i), rd_log[i], 32'h5A5A0200 + 32'(4 * i));
    end
    chk("lin_err", {31'b0, err_seen}, 0);

    // wrap4 from 0x0C
    issue(32'h0C, 5'd4, 1'b0, 2'b01);
    wait_done("wrap_done");
    chk("wrap_addr0", addr_log[0], 32'h0C);
    chk("wrap_addr1", addr_log[1], 32'h00);
    chk("wrap_addr2", addr_log[2], 32'h04);
    chk("wrap_addr3", addr_log[3], 32'h08);
    chk("wrap_bte", {30'b0, bte_log[2]}, 1);
    chk("wrap_rd1", rd_log[1], 32'h5A5A0000);

    // write burst of 3 with a two-cycle source gap after beat 1
    issue(32'h300, 5'd3, 1'b1, 2'b00);
    @(posedge clk);
    #1 wr_en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 wr_en = 1'b1;
    wait_done("wr_done");
    chk("wr_ready_cnt", wr_cnt, 3);
    chk("wr_gap_cycles", gap_cnt, 2);
    chk("wr_gap_addr", gap_addr, 32'h304);
    chk("wr_gap_cti", {29'b0, gap_cti}, 2);
    chk("wr_cti_last", {29'b0, cti_log[2]}, 7);
    chk("wr_mem0", wmem[0], 32'hAABBCCDD);
    chk("wr_mem1", wmem[1], 32'hFFFF5678);
    chk("wr_mem2", wmem[2], 32'hCAFFFFFF);
    chk("wr_mem3", wmem[3], 32'hFFFFFFFF);

    // error on the third beat of an 8-beat read
    err_at = 2;
    issue(32'h400, 5'd8, 1'b0, 2'b00);
    wait_done("errb_done");
    err_at = 99;
    chk("errb_err", {31'b0, err_seen}, 1);
    chk("errb_rd_cnt", rd_log.size(), 2);
    chk("errb_rd1", rd_log[1], 32'h5A5A0404);
    chk("errb_cyc_at_done", {31'b0, cyc_at_done}, 0);
    chk("errb_stb_cycles", stb_cnt, 3);
    issue(32'h104, 5'd0, 1'b0, 2'b00);
    wait_done("after_err_done");
    chk("after_err_err", {31'b0, err_seen}, 0);
    chk("after_err_rd", rd_log[0], 32'h5A5A0104);
    chk("after_err_cti", {29'b0, cti_log[0]}, 0);

    // reset during beat 2 of a 4-beat read
    issue(32'h500, 5'd4, 1'b0, 2'b00);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstmid_cyc", {31'b0, wbm_cyc}, 0);
    chk("rstmid_stb", {31'b0, wbm_stb}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rstmid_no_done", done_cnt, 0);
    chk("rstmid_ready", {31'b0, cmd_ready}, 1);
    issue(32'h108, 5'd1, 1'b0, 2'b00);
    wait_done("after_rst_done");
    chk("after_rst_rd", rd_log[0], 32'h5A5A0108);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
